// File: rtl/fetch_seq.sv
// Byte-serial instruction fetch sequencer: reads one instruction byte per memory ack,
// decodes length from byte 0 and presents icode/ifun/rA/rB/valC/valP. Option: FETCH_INVALID_TRAP_EN.
module fetch_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [63:0] pc,
  output logic        fetch_ack,
  output logic        imem_rd,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        imem_error,
  output logic        instr_invalid,
  output logic        busy
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        len_q, len_d;
  logic              regids_q, regids_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [3:0]        icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0]       valc_q, valc_d, valp_q, valp_d;
  logic              err_q, err_d, inv_q, inv_d;

  logic [3:0]        dec_len;
  logic              dec_regids, dec_inv, last, ack_c;
  logic [2:0]        vbyte;

  // Length and layout of the instruction, decoded from the high nibble of byte 0.
  always_comb begin
    dec_len    = 4'd1;
    dec_regids = 1'b0;
    dec_inv    = 1'b0;
    unique case (imem_rdata[7:4])
      4'h0, 4'h1, 4'h9:       dec_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin dec_len = 4'd2;  dec_regids = 1'b1; end
      4'h7, 4'h8:             dec_len = 4'd9;
      4'h3, 4'h4, 4'h5:       begin dec_len = 4'd10; dec_regids = 1'b1; end
      default: begin
`ifdef FETCH_INVALID_TRAP_EN
        dec_inv = 1'b1;
`else
        dec_inv = 1'b0;
`endif
      end
    endcase
  end

  // Position of the current byte within valC.
  assign vbyte = 3'(idx_q - (regids_q ? 4'd2 : 4'd1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    idx_d    = idx_q;
    len_d    = len_q;
    regids_d = regids_q;
    wait_d   = wait_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    valc_d   = valc_q;
    valp_d   = valp_q;
    err_d    = err_q;
    inv_d    = inv_q;
    last     = 1'b0;
    ack_c    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_req) begin
          ack_c    = 1'b1;
          pc_d     = pc;
          idx_d    = '0;
          len_d    = 4'd1;
          regids_d = 1'b0;
          wait_d   = '0;
          icode_d  = '0;
          ifun_d   = '0;
          ra_d     = 4'hF;
          rb_d     = 4'hF;
          valc_d   = '0;
          valp_d   = '0;
          err_d    = 1'b0;
          inv_d    = 1'b0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          wait_d = '0;
          idx_d  = idx_q + 4'd1;
          if (idx_q == 4'd0) begin
            icode_d  = imem_rdata[7:4];
            ifun_d   = imem_rdata[3:0];
            len_d    = dec_len;
            regids_d = dec_regids;
            inv_d    = dec_inv;
            valp_d   = pc_q + {60'd0, dec_len};
            last     = (dec_len == 4'd1);
          end else begin
            if (regids_q && idx_q == 4'd1) begin
              ra_d = imem_rdata[7:4];
              rb_d = imem_rdata[3:0];
            end else begin
              valc_d[{vbyte, 3'b000} +: 8] = imem_rdata;
            end
            last = (idx_q == len_q - 4'd1);
          end
          if (last) state_d = StDone;
        end else if (wait_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      idx_q    <= '0;
      len_q    <= 4'd1;
      regids_q <= 1'b0;
      wait_q   <= '0;
      icode_q  <= '0;
      ifun_q   <= '0;
      ra_q     <= 4'hF;
      rb_q     <= 4'hF;
      valc_q   <= '0;
      valp_q   <= '0;
      err_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      regids_q <= regids_d;
      wait_q   <= wait_d;
      icode_q  <= icode_d;
      ifun_q   <= ifun_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      valc_q   <= valc_d;
      valp_q   <= valp_d;
      err_q    <= err_d;
      inv_q    <= inv_d;
    end
  end

  // No acceptance is signalled while reset is asserted.
  assign fetch_ack     = ack_c & ~reset;
  assign imem_rd       = (state_q == StFetch);
  assign imem_addr     = imem_rd ? pc_q + {60'd0, idx_q} : '0;
  assign out_valid     = (state_q == StDone);
  assign busy          = (state_q != StIdle);
  assign icode         = icode_q;
  assign ifun          = ifun_q;
  assign rA            = ra_q;
  assign rB            = rb_q;
  assign valC          = valc_q;
  assign valP          = valp_q;
  assign imem_error    = err_q;
  assign instr_invalid = inv_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq: normal fetches, stalls, timeout,
// undefined icode, address wrap and mid-fetch reset.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset, fetch_req, imem_ack, out_ready;
  logic [63:0] pc;
  logic [7:0]  imem_rdata;
  logic        fetch_ack, imem_rd, out_valid, imem_error, instr_invalid, busy;
  logic [63:0] imem_addr, valC, valP;
  logic [3:0]  icode, ifun, rA, rB;

`ifdef FETCH_INVALID_TRAP_EN
  localparam logic ExpInv = 1'b1;
`else
  localparam logic ExpInv = 1'b0;
`endif

  fetch_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .fetch_ack(fetch_ack),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .imem_error(imem_error), .instr_invalid(instr_invalid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First instruction byte in the most significant position.
  task automatic load(input logic [79:0] bytes);
    for (int i = 0; i < 10; i++) mem[i] = bytes[79-8*i -: 8];
  endtask

  // Accept a fetch, then deliver n bytes with gap idle cycles between acks.
  task automatic do_fetch(input logic [63:0] a, input int n, input int gap);
    fetch_req = 1'b1;
    pc        = a;
    #1;
    chk("fetch_ack", {63'd0, fetch_ack}, 64'd1);
    tick();
    fetch_req = 1'b0;
    pc        = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          imem_ack = 1'b0;
          #1;
          chk("stall_rd", {63'd0, imem_rd}, 64'd1);
          chk("stall_valid", {63'd0, out_valid}, 64'd0);
          tick();
        end
      end
      imem_ack   = 1'b1;
      imem_rdata = mem[i];
      #1;
      chk("imem_rd", {63'd0, imem_rd}, 64'd1);
      chk("imem_addr", imem_addr, a + 64'(i));
      chk("early_valid", {63'd0, out_valid}, 64'd0);
      tick();
    end
    imem_ack   = 1'b0;
    imem_rdata = '0;
    #1;
    chk("out_valid", {63'd0, out_valid}, 64'd1);
    chk("rd_done", {63'd0, imem_rd}, 64'd0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
    pc = '0; imem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_rd", {63'd0, imem_rd}, 64'd0);
    chk("rst_rA", {60'd0, rA}, 64'hF);
    chk("rst_rB", {60'd0, rB}, 64'hF);
    chk("rst_valP", valP, 64'd0);

    // irmovq $0xA, %rdx at 0x100
    load(80'h30F20A00000000000000);
    do_fetch(64'h100, 10, 0);
    chk("t1_icode", {60'd0, icode}, 64'h3);
    chk("t1_ifun", {60'd0, ifun}, 64'h0);
    chk("t1_rA", {60'd0, rA}, 64'hF);
    chk("t1_rB", {60'd0, rB}, 64'h2);
    chk("t1_valC", valC, 64'hA);
    chk("t1_valP", valP, 64'h10A);
    chk("t1_err", {63'd0, imem_error}, 64'd0);
    release_out();

    // jmp 0x300 at 0x200
    load(80'h70000300000000000000);
    do_fetch(64'h200, 9, 0);
    chk("t2_icode", {60'd0, icode}, 64'h7);
    chk("t2_rA", {60'd0, rA}, 64'hF);
    chk("t2_rB", {60'd0, rB}, 64'hF);
    chk("t2_valC", valC, 64'h300);
    chk("t2_valP", valP, 64'h209);
    release_out();

    // addq with stalled memory and stalled consumer
    load(80'h60230000000000000000);
    do_fetch(64'h0, 2, 2);
    fetch_req = 1'b1;
    pc        = 64'h999;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("t3_no_ack", {63'd0, fetch_ack}, 64'd0);
      chk("t3_icode", {60'd0, icode}, 64'h6);
      chk("t3_rA", {60'd0, rA}, 64'h2);
      chk("t3_rB", {60'd0, rB}, 64'h3);
      chk("t3_valP", valP, 64'h2);
      chk("t3_valC", valC, 64'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_release_no_ack", {63'd0, fetch_ack}, 64'd0);
    tick();
    out_ready = 1'b0;
    fetch_req = 1'b0;
    #1;
    chk("t3_idle", {63'd0, busy}, 64'd0);

    // no imem_ack at all: timeout after 16 waiting cycles
    fetch_req = 1'b1;
    pc        = 64'h300;
    #1;
    chk("t4_ack", {63'd0, fetch_ack}, 64'd1);
    tick();
    fetch_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("t4_wait_valid", {63'd0, out_valid}, 64'd0);
      chk("t4_wait_rd", {63'd0, imem_rd}, 64'd1);
      tick();
    end
    chk("t4_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_err", {63'd0, imem_error}, 64'd1);
    chk("t4_rd", {63'd0, imem_rd}, 64'd0);
    release_out();

    // undefined icode 0xC
    load(80'hC0000000000000000000);
    do_fetch(64'h500, 1, 0);
    chk("t5_inv", {63'd0, instr_invalid}, {63'd0, ExpInv});
    chk("t5_icode", {60'd0, icode}, 64'hC);
    chk("t5_valP", valP, 64'h501);
    chk("t5_err_cleared", {63'd0, imem_error}, 64'd0);
    release_out();

    // rrmovq straddling the top of the address space
    load(80'h20120000000000000000);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    chk("t6_rA", {60'd0, rA}, 64'h1);
    chk("t6_rB", {60'd0, rB}, 64'h2);
    chk("t6_valP", valP, 64'h1);
    release_out();

    // reset after 4 bytes of irmovq; the byte acked during reset is dropped
    load(80'h30F20A00000000000000);
    fetch_req = 1'b1;
    pc        = 64'h600;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[i];
      tick();
    end
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 8'h55;
    tick();
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("t7_busy", {63'd0, busy}, 64'd0);
    chk("t7_valid", {63'd0, out_valid}, 64'd0);
    chk("t7_rd", {63'd0, imem_rd}, 64'd0);
    chk("t7_addr", imem_addr, 64'd0);
    chk("t7_icode", {60'd0, icode}, 64'd0);
    chk("t7_rA", {60'd0, rA}, 64'hF);
    chk("t7_rB", {60'd0, rB}, 64'hF);
    chk("t7_valC", valC, 64'd0);
    chk("t7_valP", valP, 64'd0);
    load(80'h61450000000000000000);
    do_fetch(64'h40, 2, 0);
    chk("t7_icode2", {60'd0, icode}, 64'h6);
    chk("t7_ifun2", {60'd0, ifun}, 64'h1);
    chk("t7_rA2", {60'd0, rA}, 64'h4);
    chk("t7_rB2", {60'd0, rB}, 64'h5);
    chk("t7_valP2", valP, 64'h42);
    release_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
